// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 800x600@72 timing, coordinate widths and helpers
// shared by the sync generator and the sprite address generators.
package vga_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int DEF_H_VISIBLE = 800;
  localparam int DEF_H_FP      = 56;
  localparam int DEF_H_SYNC    = 120;
  localparam int DEF_H_BP      = 64;

  localparam int DEF_V_VISIBLE = 600;
  localparam int DEF_V_FP      = 37;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 23;

  function automatic int span_total(
    input int vis,
    input int fp,
    input int sync,
    input int bp
  );
    return vis + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL =
    span_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL =
    span_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  function automatic logic sync_level(
    input logic on,
    input logic pol
  );
    return on ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH x WIDTH shift register, async reset and
// synchronous flush both load the per-bit idle value RST_VAL.
module sync_delay_line #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = RST_VAL;
    end
    if (!flush_i) begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters with registered active/sync/pulse flags.
// Define SYNC_DELAY_EN to delay hsync/vsync/active by SYNC_DELAY clocks.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_POL      = 1'b1,
  parameter bit V_POL      = 1'b1,
  parameter int SYNC_DELAY = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic [X_W-1:0] p_x,
  output logic [Y_W-1:0] p_y,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL =
    span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  localparam logic [X_W-1:0] H_LAST =
    X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT =
    X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] HS_FIRST =
    X_W'(H_VISIBLE + H_FP);
  localparam logic [X_W-1:0] HS_LAST =
    X_W'(H_VISIBLE + H_FP + H_SYNC - 1);

  localparam logic [Y_W-1:0] V_LAST =
    Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT =
    Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] VS_FIRST =
    Y_W'(V_VISIBLE + V_FP);
  localparam logic [Y_W-1:0] VS_LAST =
    Y_W'(V_VISIBLE + V_FP + V_SYNC - 1);

`ifdef SYNC_DELAY_EN
  localparam bit DLY_EN = 1'b1;
`else
  localparam bit DLY_EN = 1'b0;
`endif

  logic [X_W-1:0] x_q;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_q;
  logic [Y_W-1:0] y_d;

  logic act_q;
  logic act_d;
  logic hs_q;
  logic hs_d;
  logic vs_q;
  logic vs_d;
  logic ls_q;
  logic ls_d;
  logic fs_q;
  logic fs_d;

  logic hs_on;
  logic vs_on;

  // run=0 parks the raster at 0,0 rather than freezing it
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (run) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        y_d = y_q;
      end
    end
  end

  // Decode from the next coordinates so flags line up with p_x/p_y
  always_comb begin
    hs_on = run && (x_d >= HS_FIRST) && (x_d <= HS_LAST);
    vs_on = run && (y_d >= VS_FIRST) && (y_d <= VS_LAST);
    act_d = run && (x_d < H_ACT) && (y_d < V_ACT);
    hs_d  = sync_level(hs_on, H_POL);
    vs_d  = sync_level(vs_on, V_POL);
    ls_d  = run && (x_d == '0);
    fs_d  = ls_d && (y_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      act_q <= 1'b0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  assign p_x         = x_q;
  assign p_y         = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  // Delay matches the sprite ROM latency; pulses stay undelayed
  if (DLY_EN && SYNC_DELAY > 0) begin : g_dly
    sync_delay_line #(
      .DEPTH   (SYNC_DELAY),
      .WIDTH   (3),
      .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_dly (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (~run),
      .d_i     ({act_q, hs_q, vs_q}),
      .q_o     ({active, hsync, vsync})
    );
  end else begin : g_nodly
    assign active = act_q;
    assign hsync  = hs_q;
    assign vsync  = vs_q;
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default-timing and reduced-timing instances checked
// every cycle against a raster-position model plus literal expectations.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int SD = 2;
`ifdef SYNC_DELAY_EN
  localparam int DL = SD;
`else
  localparam int DL = 0;
`endif

  localparam int BHT = 1040;
  localparam int BVT = 666;
  localparam int SHT = 15;
  localparam int SVT = 10;

  typedef struct packed {
    logic [10:0] px;
    logic [9:0]  py;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;

  logic [10:0] b_px;
  logic [9:0]  b_py;
  logic        b_act, b_hs, b_vs, b_ls, b_fs;
  logic [10:0] s_px;
  logic [9:0]  s_py;
  logic        s_act, s_hs, s_vs, s_ls, s_fs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .SYNC_DELAY (SD)
  ) u_big (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .p_x         (b_px),
    .p_y         (b_py),
    .active      (b_act),
    .hsync       (b_hs),
    .vsync       (b_vs),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE  (8),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (2),
    .V_VISIBLE  (5),
    .V_FP       (2),
    .V_SYNC     (2),
    .V_BP       (1),
    .H_POL      (1'b0),
    .V_POL      (1'b0),
    .SYNC_DELAY (SD)
  ) u_small (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .p_x         (s_px),
    .p_y         (s_py),
    .active      (s_act),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Outputs as a function of scan position since the last (re)start
  function automatic exp_t expect_at(
    input int pos, input bit adv,
    input int hv, input int hfp, input int hsw, input int hbp,
    input int vv, input int vfp, input int vsw,
    input bit hp, input bit vp
  );
    exp_t e;
    int ht, x, y;
    bit hon, von;
    ht = hv + hfp + hsw + hbp;
    x = pos % ht;
    y = pos / ht;
    hon = adv && (x >= hv + hfp) && (x < hv + hfp + hsw);
    von = adv && (y >= vv + vfp) && (y < vv + vfp + vsw);
    e.px = 11'(x);
    e.py = 10'(y);
    e.act = adv && (x < hv) && (y < vv);
    e.hs = hon ? hp : !hp;
    e.vs = von ? vp : !vp;
    e.ls = adv && (x == 0);
    e.fs = adv && (x == 0) && (y == 0);
    return e;
  endfunction

  function automatic exp_t exp_big(input int pos, input bit adv);
    return expect_at(pos, adv, 800, 56, 120, 64, 600, 37, 6,
                     1'b1, 1'b1);
  endfunction

  function automatic exp_t exp_small(input int pos, input bit adv);
    return expect_at(pos, adv, 8, 2, 3, 2, 5, 2, 2, 1'b0, 1'b0);
  endfunction

  int b_pos = 0;
  int s_pos = 0;
  bit adv = 1'b0;
  exp_t mb, ms, ce_b, ce_s;
`ifdef SYNC_DELAY_EN
  logic [2:0] bh [SD];
  logic [2:0] sh [SD];
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      b_pos = 0;
      s_pos = 0;
      adv = 1'b0;
`ifdef SYNC_DELAY_EN
      for (int k = 0; k < SD; k++) begin
        bh[k] = 3'b000;
        sh[k] = 3'b011;
      end
`endif
    end else begin
`ifdef SYNC_DELAY_EN
      mb = exp_big(b_pos, adv);
      ms = exp_small(s_pos, adv);
      for (int k = SD - 1; k > 0; k--) begin
        bh[k] = bh[k-1];
        sh[k] = sh[k-1];
      end
      bh[0] = {mb.act, mb.hs, mb.vs};
      sh[0] = {ms.act, ms.hs, ms.vs};
      if (!run) begin
        for (int k = 0; k < SD; k++) begin
          bh[k] = 3'b000;
          sh[k] = 3'b011;
        end
      end
`endif
      if (run) begin
        b_pos = (b_pos + 1) % (BHT * BVT);
        s_pos = (s_pos + 1) % (SHT * SVT);
        adv = 1'b1;
      end else begin
        b_pos = 0;
        s_pos = 0;
        adv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    ce_b = exp_big(b_pos, adv);
    ce_s = exp_small(s_pos, adv);
`ifdef SYNC_DELAY_EN
    {ce_b.act, ce_b.hs, ce_b.vs} = bh[SD-1];
    {ce_s.act, ce_s.hs, ce_s.vs} = sh[SD-1];
`endif
    chk("big_px", b_px, ce_b.px);
    chk("big_py", b_py, ce_b.py);
    chk("big_active", b_act, ce_b.act);
    chk("big_hsync", b_hs, ce_b.hs);
    chk("big_vsync", b_vs, ce_b.vs);
    chk("big_line_start", b_ls, ce_b.ls);
    chk("big_frame_start", b_fs, ce_b.fs);
    chk("small_px", s_px, ce_s.px);
    chk("small_py", s_py, ce_s.py);
    chk("small_active", s_act, ce_s.act);
    chk("small_hsync", s_hs, ce_s.hs);
    chk("small_vsync", s_vs, ce_s.vs);
    chk("small_line_start", s_ls, ce_s.ls);
    chk("small_frame_start", s_fs, ce_s.fs);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int ls_cnt, found, prev_fs, nfs, nh, nv, hrun, vrun;
    bit hprev, vprev, hin, vin;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_px", b_px, 0);
    chk("rst_py", b_py, 0);
    chk("rst_active", b_act, 0);
    chk("rst_hs_big", b_hs, 0);
    chk("rst_hs_small", s_hs, 1);
    chk("rst_vs_small", s_vs, 1);
    chk("rst_ls", b_ls, 0);
    chk("rst_fs", b_fs, 0);

    // Default timing: first line, wrap and hsync/active edges
    reset = 1'b0;
    run = 1'b1;
    ls_cnt = 0;
    for (int i = 1; i <= 1040; i++) begin
      @(negedge clk);
      if (b_ls) ls_cnt++;
      if (i == 1) chk("first_px", b_px, 1);
      if (i == 1) chk("first_fs", b_fs, 0);
      if (i == 799 + DL) chk("act_799", b_act, 1);
      if (i == 800 + DL) chk("act_800", b_act, 0);
      if (i == 855 + DL) chk("hs_855", b_hs, 0);
      if (i == 856 + DL) chk("hs_856", b_hs, 1);
      if (i == 975 + DL) chk("hs_975", b_hs, 1);
      if (i == 976 + DL) chk("hs_976", b_hs, 0);
    end
    chk("wrap_px", b_px, 0);
    chk("wrap_py", b_py, 1);
    chk("wrap_ls", b_ls, 1);
    chk("ls_count", ls_cnt, 1);

    // Reduced timing: frame period, sync widths, active boundary
    nfs = 0;
    prev_fs = -1;
    nh = 0;
    nv = 0;
    hrun = 0;
    vrun = 0;
    hin = 1'b0;
    vin = 1'b0;
    hprev = !s_hs;
    vprev = !s_vs;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (s_fs) begin
        if (prev_fs >= 0) chk("fs_period", c - prev_fs, 150);
        prev_fs = c;
        nfs++;
      end
      if (!s_hs) begin
        if (!hprev) begin
          hin = 1'b1;
          hrun = 0;
        end
        hrun++;
      end else if (hprev && hin) begin
        chk("hs_width", hrun, 3);
        nh++;
        hin = 1'b0;
      end
      hprev = !s_hs;
      if (!s_vs) begin
        if (!vprev) begin
          vin = 1'b1;
          vrun = 0;
          chk("vs_start_y", s_py, 7);
          chk("vs_start_x", s_px, DL);
        end
        vrun++;
      end else if (vprev && vin) begin
        chk("vs_width", vrun, 30);
        nv++;
        vin = 1'b0;
      end
      vprev = !s_vs;
      if (s_py == 4 && s_px == 11'(7 + DL)) chk("act_last_line", s_act, 1);
      if (s_py == 5 && s_px == 11'(DL)) chk("act_first_blank", s_act, 0);
    end
    chk("fs_seen", nfs >= 2, 1);
    chk("hs_seen", nh >= 10, 1);
    chk("vs_seen", nv >= 2, 1);

    // Hold mid-frame, then resume from 0,0 without a frame pulse
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (s_px == 5 && s_py == 3) found = 1;
    end
    chk("hold_point_reached", found, 1);
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_px", s_px, 0);
      chk("hold_py", s_py, 0);
      chk("hold_act", s_act, 0);
      chk("hold_fs", s_fs, 0);
      chk("hold_big_px", b_px, 0);
    end
    run = 1'b1;
    @(negedge clk);
    chk("resume_px", s_px, 1);
    chk("resume_py", s_py, 0);
    chk("resume_fs", s_fs, 0);
    chk("resume_ls", s_ls, 0);

    // Asynchronous reset between clock edges
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      @(negedge clk);
      if (s_px == 4 && s_py == 1) found = 1;
    end
    chk("async_point_reached", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_small_px", s_px, 0);
    chk("async_small_py", s_py, 0);
    chk("async_small_act", s_act, 0);
    chk("async_small_hs", s_hs, 1);
    chk("async_big_px", b_px, 0);
    chk("async_big_ls", b_ls, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
